t05_histogram_rmw: RTL and testbench

Histogram build stage directly upstream of the SRAM interface. Consumes the input byte stream and keeps one 32-bit occurrence count per byte value (256 entries) in SRAM. Each count is updated with a serialized read-modify-write: the count is read, incremented with saturation, and written back. Before counting starts, the block zeroes all 256 entries, and it reports the total byte count and completion to the controller.

---
 rtl/t05_pkg.sv | 28 ++
 rtl/t05_sat_inc.sv | 18 +
 rtl/t05_histogram_rmw.sv | 205 ++++++++++++++++++++
 tb/tb_t05_histogram_rmw.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_pkg.sv
// Shared definitions for the t05 encoder: histogram FSM states, controller
// state codes used by the SRAM interface, and the histogram base address.
package t05_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR_ISSUE,
        S_CLR_WAIT,
        S_WAIT_CHAR,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_DONE
    } hist_state_t;

    typedef enum logic [2:0] {
        A_IDLE,
        HIST,
        FLV,
        CODEBOOK,
        TRANSLATION
    } ctrl_state_t;

    // Word address of bin 0 inside the SRAM; the interface adds it after scaling.
    localparam logic [31:0] HIST_BASE = 32'd0;

endpackage

// File: rtl/t05_sat_inc.sv
// Combinational saturating incrementer: all-ones stays all-ones.
module t05_sat_inc #(
    parameter int CNT_W = 32
) (
    input  logic [CNT_W-1:0] i_val,
    output logic [CNT_W-1:0] o_val
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign o_val = sat_inc(i_val);

endmodule

// File: rtl/t05_histogram_rmw.sv
// Histogram build stage: clears NUM_BINS SRAM counters, then performs one
// serialized read-modify-write per accepted byte and tracks the byte total.
module t05_histogram_rmw
    import t05_pkg::*;
#(
    parameter int NUM_BINS = 256,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_char,
    output logic             in_ready,
    input  logic             eof,
    output logic             hist_req,
    output logic             hist_r_wr,
    output logic [7:0]       histgram_addr,
    output logic [CNT_W-1:0] histogram,
    input  logic [CNT_W-1:0] old_char,
    input  logic             busy_o,
    output logic [CNT_W-1:0] total,
    output logic             hist_active,
    output logic             hist_done
);

    // Bin index mask; the last clear index equals it as well.
    localparam logic [7:0] BIN_MASK = 8'(NUM_BINS - 1);

    hist_state_t      r_state;
    hist_state_t      w_state_nxt;

    logic             r_seen_busy;
    logic [7:0]       r_clr_idx;
    logic [7:0]       r_cur_char;
    logic             r_hist_r_wr;
    logic [7:0]       r_addr;
    logic [CNT_W-1:0] r_histogram;
    logic [CNT_W-1:0] r_total;
    logic             r_in_ready;
    logic             r_hist_active;
    logic             r_hist_done;

    logic             w_hist_req;
    logic             w_seen_nxt;
    logic [7:0]       w_clr_nxt;
    logic [7:0]       w_char_nxt;
    logic             w_wr_nxt;
    logic [7:0]       w_addr_nxt;
    logic [CNT_W-1:0] w_histo_nxt;
    logic [CNT_W-1:0] w_total_nxt;
    logic             w_xfer_done;
    logic [CNT_W-1:0] w_bin_inc;
    logic [CNT_W-1:0] w_total_inc;

    t05_sat_inc #(.CNT_W(CNT_W)) u_inc_bin (
        .i_val (old_char),
        .o_val (w_bin_inc)
    );

    t05_sat_inc #(.CNT_W(CNT_W)) u_inc_total (
        .i_val (r_total),
        .o_val (w_total_inc)
    );

    // An SRAM access completes on the first idle cycle after busy was seen high.
    assign w_xfer_done = r_seen_busy && !busy_o;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, request strobe and next values of the held command registers.
    always_comb begin
        w_state_nxt = r_state;
        w_hist_req  = 1'b0;
        w_seen_nxt  = r_seen_busy;
        w_clr_nxt   = r_clr_idx;
        w_char_nxt  = r_cur_char;
        w_wr_nxt    = r_hist_r_wr;
        w_addr_nxt  = r_addr;
        w_histo_nxt = r_histogram;
        w_total_nxt = r_total;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_CLR_ISSUE;
                    w_clr_nxt   = 8'd0;
                    w_total_nxt = '0;
                    w_addr_nxt  = 8'd0;
                    w_wr_nxt    = 1'b1;
                    w_histo_nxt = '0;
                end
            end
            S_CLR_ISSUE: begin
                if (!busy_o) begin
                    w_hist_req  = 1'b1;
                    w_seen_nxt  = 1'b0;
                    w_state_nxt = S_CLR_WAIT;
                end
            end
            S_CLR_WAIT: begin
                if (busy_o) begin
                    w_seen_nxt = 1'b1;
                end else if (r_seen_busy) begin
                    if (r_clr_idx == BIN_MASK) begin
                        w_state_nxt = S_WAIT_CHAR;
                    end else begin
                        w_clr_nxt   = r_clr_idx + 8'd1;
                        w_addr_nxt  = r_clr_idx + 8'd1;
                        w_state_nxt = S_CLR_ISSUE;
                    end
                end
            end
            S_WAIT_CHAR: begin
                // A byte wins over eof; eof is looked at again on return here.
                if (in_valid) begin
                    w_char_nxt  = in_char & BIN_MASK;
                    w_addr_nxt  = in_char & BIN_MASK;
                    w_wr_nxt    = 1'b0;
                    w_state_nxt = S_RD_ISSUE;
                end else if (eof) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_RD_ISSUE: begin
                if (!busy_o) begin
                    w_hist_req  = 1'b1;
                    w_seen_nxt  = 1'b0;
                    w_state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (busy_o) begin
                    w_seen_nxt = 1'b1;
                end else if (w_xfer_done) begin
                    w_histo_nxt = w_bin_inc;
                    w_wr_nxt    = 1'b1;
                    w_addr_nxt  = r_cur_char;
                    w_state_nxt = S_WR_ISSUE;
                end
            end
            S_WR_ISSUE: begin
                if (!busy_o) begin
                    w_hist_req  = 1'b1;
                    w_seen_nxt  = 1'b0;
                    w_state_nxt = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (busy_o) begin
                    w_seen_nxt = 1'b1;
                end else if (w_xfer_done) begin
                    w_total_nxt = w_total_inc;
                    w_state_nxt = S_WAIT_CHAR;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and status registers; status flags are decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seen_busy   <= 1'b0;
            r_clr_idx     <= 8'd0;
            r_cur_char    <= 8'd0;
            r_hist_r_wr   <= 1'b0;
            r_addr        <= 8'd0;
            r_histogram   <= '0;
            r_total       <= '0;
            r_in_ready    <= 1'b0;
            r_hist_active <= 1'b0;
            r_hist_done   <= 1'b0;
        end else begin
            r_seen_busy   <= w_seen_nxt;
            r_clr_idx     <= w_clr_nxt;
            r_cur_char    <= w_char_nxt;
            r_hist_r_wr   <= w_wr_nxt;
            r_addr        <= w_addr_nxt;
            r_histogram   <= w_histo_nxt;
            r_total       <= w_total_nxt;
            r_in_ready    <= (w_state_nxt == S_WAIT_CHAR);
            r_hist_active <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_hist_done   <= (w_state_nxt == S_DONE);
        end
    end

    assign hist_req      = w_hist_req;
    assign hist_r_wr     = r_hist_r_wr;
    assign histgram_addr = r_addr;
    assign histogram     = r_histogram;
    assign total         = r_total;
    assign in_ready      = r_in_ready;
    assign hist_active   = r_hist_active;
    assign hist_done     = r_hist_done;

endmodule

// File: tb/tb_t05_histogram_rmw.sv
// Bench for t05_histogram_rmw: SRAM responder with one-cycle busy, directed
// scenarios plus a randomized byte stream checked against a bin-count model.
module tb_t05_histogram_rmw;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic        eof;
    logic        hist_req;
    logic        hist_r_wr;
    logic [7:0]  histgram_addr;
    logic [31:0] histogram;
    logic [31:0] old_char = 32'd0;
    logic        busy_o;
    logic [31:0] total;
    logic        hist_active;
    logic        hist_done;

    logic        model_busy = 1'b0;
    logic        stall;
    logic        poke_en;
    logic [7:0]  poke_addr;
    logic [31:0] poke_data;

    logic [31:0] mem [256];
    logic [31:0] ref_hist [256];
    logic [31:0] ref_total;

    int          log_n = 0;
    logic        log_wr   [4096];
    logic [7:0]  log_addr [4096];
    logic [31:0] log_data [4096];

    int checks = 0;
    int errors = 0;

    t05_histogram_rmw dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_valid      (in_valid),
        .in_char       (in_char),
        .in_ready      (in_ready),
        .eof           (eof),
        .hist_req      (hist_req),
        .hist_r_wr     (hist_r_wr),
        .histgram_addr (histgram_addr),
        .histogram     (histogram),
        .old_char      (old_char),
        .busy_o        (busy_o),
        .total         (total),
        .hist_active   (hist_active),
        .hist_done     (hist_done)
    );

    always #5 clk = ~clk;

    assign busy_o = model_busy | stall;

    // SRAM responder: takes a command when hist_req is high at a clock edge,
    // raises busy for the following cycle, logs every command.
    always @(posedge clk) begin
        if (rst) begin
            model_busy <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
        end else begin
            if (poke_en) mem[poke_addr] <= poke_data;
            model_busy <= hist_req;
            if (hist_req) begin
                if (log_n < 4096) begin
                    log_wr[log_n[11:0]]   <= hist_r_wr;
                    log_addr[log_n[11:0]] <= histgram_addr;
                    log_data[log_n[11:0]] <= histogram;
                end
                log_n <= log_n + 1;
                if (hist_r_wr) mem[histgram_addr] <= histogram;
                else           old_char <= mem[histgram_addr];
            end
        end
    end

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_hist_req"}, 32'(hist_req), 32'd0);
        check({tag, "_r_wr"}, 32'(hist_r_wr), 32'd0);
        check({tag, "_addr"}, 32'(histgram_addr), 32'd0);
        check({tag, "_histogram"}, histogram, 32'd0);
        check({tag, "_total"}, total, 32'd0);
        check({tag, "_active"}, 32'(hist_active), 32'd0);
        check({tag, "_done"}, 32'(hist_done), 32'd0);
    endtask

    task automatic ref_clear();
        for (int i = 0; i < 256; i++) ref_hist[i] = 32'd0;
        ref_total = 32'd0;
    endtask

    task automatic pulse_start();
        sync();
        start = 1'b1;
        sync();
        start = 1'b0;
    endtask

    task automatic wait_ready(input int limit);
        int n;
        n = 0;
        while (!in_ready && n < limit) begin
            sync();
            n++;
        end
        check("ready_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready(200);
        in_valid = 1'b1;
        in_char  = b;
        sync();
        in_valid = 1'b0;
        if (ref_hist[b] != 32'hFFFF_FFFF) ref_hist[b] = ref_hist[b] + 32'd1;
        ref_total = ref_total + 32'd1;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!hist_done && n < limit) begin
            sync();
            n++;
        end
        check("done_wait", 32'(hist_done), 32'd1);
    endtask

    task automatic end_stream();
        wait_ready(200);
        eof = 1'b1;
        wait_done(20);
        eof = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        sync();
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        sync();
        poke_en   = 1'b0;
        ref_hist[a] = d;
    endtask

    task automatic check_clear(input int base);
        int bad;
        int nz;
        logic [11:0] k;
        check("clr_count", 32'(log_n - base), 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            k = 12'(base + i);
            if (log_wr[k] !== 1'b1 || log_addr[k] !== 8'(i) || log_data[k] !== 32'd0) bad++;
        end
        check("clr_order", 32'(bad), 32'd0);
        nz = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 32'd0) nz++;
        check("clr_mem_nonzero", 32'(nz), 32'd0);
    endtask

    initial begin
        int base;
        int seen_req;
        logic [7:0] b;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_char = 8'd0; eof = 1'b0;
        stall = 1'b0; poke_en = 1'b0; poke_addr = 8'd0; poke_data = 32'd0;
        ref_clear();
        repeat (3) sync();
        check_reset_outputs("rst");
        rst = 1'b0;
        sync();

        // Clear pass after start.
        base = log_n;
        pulse_start();
        check("clr_active", 32'(hist_active), 32'd1);
        check("clr_in_ready", 32'(in_ready), 32'd0);
        wait_ready(2000);
        check_clear(base);
        ref_clear();

        // Repeated bytes then eof.
        send_byte(8'h41);
        send_byte(8'h41);
        send_byte(8'h42);
        end_stream();
        check("bin41", mem[8'h41], 32'd2);
        check("bin42", mem[8'h42], 32'd1);
        check("total3", total, 32'd3);
        check("done_active", 32'(hist_active), 32'd0);
        check("done_in_ready", 32'(in_ready), 32'd0);

        // Randomized stream from S_DONE; restart includes the clear pass.
        base = log_n;
        pulse_start();
        wait_ready(2000);
        check_clear(base);
        ref_clear();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) b = 8'($urandom);
            else                           b = 8'h20 + 8'($urandom_range(0, 7));
            send_byte(b);
        end
        end_stream();
        for (int i = 0; i < 256; i++) check($sformatf("rand_bin%0d", i), mem[i], ref_hist[i]);
        check("rand_total", total, ref_total);

        // Saturation at all-ones and the step into it.
        pulse_start();
        wait_ready(2000);
        ref_clear();
        poke(8'h00, 32'hFFFF_FFFF);
        poke(8'hFE, 32'hFFFF_FFFE);
        send_byte(8'h00);
        send_byte(8'hFE);
        wait_ready(200);
        check("sat_bin00", mem[8'h00], 32'hFFFF_FFFF);
        check("sat_binFE", mem[8'hFE], 32'hFFFF_FFFF);
        check("sat_wdata00", log_data[12'(log_n - 3)], 32'hFFFF_FFFF);
        check("sat_wdataFE", log_data[12'(log_n - 1)], 32'hFFFF_FFFF);

        // Busy stall ahead of the read issue.
        base = log_n;
        stall = 1'b1;
        send_byte(8'h55);
        seen_req = 0;
        for (int i = 0; i < 5; i++) begin
            if (hist_req) seen_req++;
            sync();
        end
        check("stall_req_seen", 32'(seen_req), 32'd0);
        check("stall_cmds", 32'(log_n - base), 32'd0);
        stall = 1'b0;
        wait_ready(200);
        check("stall_total_cmds", 32'(log_n - base), 32'd2);
        check("stall_rd_wr", 32'(log_wr[12'(base)]), 32'd0);
        check("stall_rd_addr", 32'(log_addr[12'(base)]), 32'h55);
        check("stall_wr_wr", 32'(log_wr[12'(base + 1)]), 32'd1);
        check("stall_wr_addr", 32'(log_addr[12'(base + 1)]), 32'h55);
        check("stall_wr_data", log_data[12'(base + 1)], ref_hist[8'h55]);

        // Byte and eof together: byte is counted first, then done.
        in_valid = 1'b1;
        in_char  = 8'h10;
        eof      = 1'b1;
        sync();
        in_valid = 1'b0;
        ref_hist[8'h10] = ref_hist[8'h10] + 32'd1;
        ref_total = ref_total + 32'd1;
        check("eofv_not_done", 32'(hist_done), 32'd0);
        check("eofv_busy_rmw", 32'(in_ready), 32'd0);
        wait_done(20);
        eof = 1'b0;
        check("eofv_bin10", mem[8'h10], 32'd1);
        check("eofv_total", total, ref_total);

        // Reset while the read is outstanding.
        pulse_start();
        wait_ready(2000);
        send_byte(8'h33);
        check("rdw_req", 32'(hist_req), 32'd1);
        check("rdw_r_wr", 32'(hist_r_wr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("rdw_rst");
        sync();
        sync();
        rst = 1'b0;
        sync();
        base = log_n;
        pulse_start();
        wait_ready(2000);
        check_clear(base);
        check("rerun_total", total, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
